// File: rtl/btb_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : btb_fetch_pc
// Purpose  : Fetch-side PC generator and prediction tracker around a branch
//            target buffer. It issues the fetch PC, which is also the BTB
//            lookup address, and uses the BTB hit/taken/target response to
//            choose the next PC. Every issued prediction is held in an
//            in-order in-flight queue and compared with the EX-stage outcome.
//            The block then drives the BTB update, the mispredict flag and
//            the pipeline flush/redirect.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   fetch_ready   in   IF/ID can accept an instruction this cycle
//   btb_valid     in   BTB hit for PC
//   btb_target    in   BTB predicted target
//   btb_taken     in   BTB taken prediction
//   ex_valid      in   instruction retires from EX (program order)
//   ex_pc         in   PC of the retiring instruction
//   ex_is_branch  in   retiring instruction is a control transfer
//   ex_taken      in   resolved direction
//   ex_target     in   resolved target
//   PC            out  fetch PC / BTB lookup address
//   fetch_valid   out  PC is issued to IF this cycle
//   pred_taken_o  out  prediction sent with the fetched instruction
//   update        out  BTB write enable
//   updatePC      out  BTB update address
//   updateTarget  out  BTB update target
//   mispredicted  out  prediction was wrong
//   flush         out  kill younger instructions in IF/ID/EX
//   order_err     out  sticky retire-order / empty-queue error
// ============================================================================
module btb_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ready,
  input  logic        btb_valid,
  input  logic [31:0] btb_target,
  input  logic        btb_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] PC,
  output logic        fetch_valid,
  output logic        pred_taken_o,
  output logic        update,
  output logic [31:0] updatePC,
  output logic [31:0] updateTarget,
  output logic        mispredicted,
  output logic        flush,
  output logic        order_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_order_err;

  logic [31:0]   r_q_pc   [DEPTH];
  logic          r_q_pred [DEPTH];
  logic [31:0]   r_q_tgt  [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_pred;
  logic          w_push;
  logic          w_pop;
  logic          w_mis;
  logic          w_upd;
  logic          w_head_pred;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_tgt;
  logic [31:0]   w_redirect;
  logic          w_order_bad;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_FULL);
  assign w_head_pc   = r_q_pc[r_head];
  assign w_head_pred = r_q_pred[r_head];
  assign w_head_tgt  = r_q_tgt[r_head];

  // Combinational outputs are qualified with rst so they read 0 while reset
  // is held, regardless of what the fetch/EX inputs are doing.
  assign w_pred = rst & btb_valid & btb_taken;
  assign w_pop  = rst & ex_valid & ~w_empty;
  assign w_upd  = w_pop & ex_is_branch;

  // A non-branch that was predicted taken was fetched down a bogus path and
  // must be redirected to its fall-through address.
  always_comb begin
    w_mis = 1'b0;
    if (w_pop) begin
      if (ex_is_branch)
        w_mis = (w_head_pred != ex_taken) |
                (ex_taken & (w_head_tgt != ex_target));
      else
        w_mis = w_head_pred;
    end
  end

  // Full is the registered occupancy, so a pop in the same cycle does not
  // open a slot for a push until the next cycle.
  assign w_push = rst & (r_state == ST_RUN) & fetch_ready & ~w_full & ~w_mis;

  assign w_redirect  = (ex_taken & ex_is_branch) ? ex_target : (ex_pc + 32'd4);
  assign w_order_bad = rst & ex_valid & (w_empty | (ex_pc != w_head_pc));

  assign PC           = r_pc;
  assign fetch_valid  = w_push;
  assign pred_taken_o = w_pred;
  assign update       = w_upd;
  assign updatePC     = w_upd ? ex_pc : 32'h0;
  assign updateTarget = w_upd ? ex_target : 32'h0;
  assign mispredicted = w_mis;
  assign flush        = w_mis;
  assign order_err    = r_order_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_mis) w_state_nxt = ST_BUBBLE;
      ST_BUBBLE: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_mis)
      w_pc_nxt = w_redirect;
    else if (w_push)
      w_pc_nxt = w_pred ? btb_target : (r_pc + 32'd4);
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_order_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_order_bad)
        r_order_err <= 1'b1;
      if (w_mis) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PW'(1);
        if (w_pop)  r_head <= r_head + PW'(1);
        r_count <= w_count_nxt;
      end
    end
  end

  // Entry storage needs no reset: it is only read while the count says the
  // entry is occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_pc;
      r_q_pred[r_tail] <= w_pred;
      r_q_tgt[r_tail]  <= btb_target;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_fetch_pc
// Purpose  : Directed self-checking bench for btb_fetch_pc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_fetch_pc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        btb_valid = 1'b0;
  logic [31:0] btb_target = 32'h0;
  logic        btb_taken = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        ex_is_branch = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic [31:0] PC;
  logic        fetch_valid;
  logic        pred_taken_o;
  logic        update;
  logic [31:0] updatePC;
  logic [31:0] updateTarget;
  logic        mispredicted;
  logic        flush;
  logic        order_err;

  int n_chk  = 0;
  int n_fail = 0;

  btb_fetch_pc #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
    .btb_valid(btb_valid), .btb_target(btb_target), .btb_taken(btb_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .PC(PC), .fetch_valid(fetch_valid), .pred_taken_o(pred_taken_o),
    .update(update), .updatePC(updatePC), .updateTarget(updateTarget),
    .mispredicted(mispredicted), .flush(flush), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b0; btb_valid = 1'b0; btb_taken = 1'b0; btb_target = 32'h0;
    ex_valid = 1'b0; ex_pc = 32'h0; ex_is_branch = 1'b0; ex_taken = 1'b0;
    ex_target = 32'h0;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic br,
                        input logic tk, input logic [31:0] tgt);
    ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic set_btb(input logic v, input logic tk, input logic [31:0] tgt);
    btb_valid = v; btb_taken = tk; btb_target = tgt;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  // Outputs are zero while reset is held, even with busy inputs.
  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b0;
    fetch_ready = 1'b1;
    set_btb(1'b1, 1'b1, 32'h0000_0500);
    set_ex(1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0600);
    tick();
    tick();
    n_chk++; if (PC !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", PC, 32'h0); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_valid: got %b expected 0", fetch_valid); end
    n_chk++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL rst_pred: got %b expected 0", pred_taken_o); end
    n_chk++; if (update !== 1'b0) begin n_fail++; $display("FAIL rst_update: got %b expected 0", update); end
    n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b expected 0", flush); end
    n_chk++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL rst_order_err: got %b expected 0", order_err); end
    idle_inputs();
    rst = 1'b1;
    #1;
  endtask

  // Sequential fetch, queue fill, stall when full, resume after a pop,
  // predicted-taken redirect, and drain with the recorded prediction checked.
  task automatic test_sequential_fill();
    do_reset();
    fetch_ready = 1'b1;
    #1;
    n_chk++; if (PC !== 32'h0) begin n_fail++; $display("FAIL seq_pc0: got %h expected %h", PC, 32'h0); end
    n_chk++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv0: got %b expected 1", fetch_valid); end
    tick();
    n_chk++; if (PC !== 32'h4) begin n_fail++; $display("FAIL seq_pc1: got %h expected %h", PC, 32'h4); end
    n_chk++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv1: got %b expected 1", fetch_valid); end
    tick();
    n_chk++; if (PC !== 32'h8) begin n_fail++; $display("FAIL seq_pc2: got %h expected %h", PC, 32'h8); end
    tick();
    n_chk++; if (PC !== 32'hC) begin n_fail++; $display("FAIL seq_pc3: got %h expected %h", PC, 32'hC); end
    n_chk++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv3: got %b expected 1", fetch_valid); end
    tick();
    // Four entries now in flight: fetch stalls and PC holds.
    n_chk++; if (PC !== 32'h10) begin n_fail++; $display("FAIL full_pc: got %h expected %h", PC, 32'h10); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL full_fv: got %b expected 0", fetch_valid); end
    tick();
    n_chk++; if (PC !== 32'h10) begin n_fail++; $display("FAIL full_hold: got %h expected %h", PC, 32'h10); end
    // Pop while full does not enable a push in the same cycle.
    set_ex(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_fv: got %b expected 0", fetch_valid); end
    n_chk++; if (mispredicted !== 1'b0) begin n_fail++; $display("FAIL full_pop_mis: got %b expected 0", mispredicted); end
    n_chk++; if (update !== 1'b0) begin n_fail++; $display("FAIL full_pop_upd: got %b expected 0", update); end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_btb(1'b1, 1'b1, 32'h100);
    #1;
    n_chk++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL resume_fv: got %b expected 1", fetch_valid); end
    n_chk++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL pred_o: got %b expected 1", pred_taken_o); end
    tick();
    set_btb(1'b0, 1'b0, 32'h0);
    fetch_ready = 1'b0;
    n_chk++; if (PC !== 32'h100) begin n_fail++; $display("FAIL taken_pc: got %h expected %h", PC, 32'h100); end
    // Drain 0x4, 0x8, 0xC as correctly predicted non-branches.
    for (int i = 1; i <= 3; i++) begin
      set_ex(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0);
      #1;
      n_chk++; if (mispredicted !== 1'b0) begin n_fail++; $display("FAIL drain_mis[%0d]: got %b expected 0", i, mispredicted); end
      tick();
    end
    // Head is 0x10, recorded as predicted taken to 0x100.
    set_ex(1'b1, 32'h10, 1'b1, 1'b1, 32'h100);
    #1;
    n_chk++; if (update !== 1'b1) begin n_fail++; $display("FAIL drain_upd: got %b expected 1", update); end
    n_chk++; if (updatePC !== 32'h10) begin n_fail++; $display("FAIL drain_updpc: got %h expected %h", updatePC, 32'h10); end
    n_chk++; if (updateTarget !== 32'h100) begin n_fail++; $display("FAIL drain_updtgt: got %h expected %h", updateTarget, 32'h100); end
    n_chk++; if (mispredicted !== 1'b0) begin n_fail++; $display("FAIL drain_pred_mis: got %b expected 0", mispredicted); end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL drain_order: got %b expected 0", order_err); end
  endtask

  // Head {0x20, not taken} resolves taken to 0x80: flush, redirect, bubble.
  task automatic test_mispredict();
    do_reset();
    fetch_ready = 1'b1;
    set_btb(1'b1, 1'b1, 32'h20);
    tick();
    set_btb(1'b0, 1'b0, 32'h0);
    // Push {0x20,0} and pop {0x0,1,0x20} which resolves correctly.
    set_ex(1'b1, 32'h0, 1'b1, 1'b1, 32'h20);
    #1;
    n_chk++; if (PC !== 32'h20) begin n_fail++; $display("FAIL mp_pc20: got %h expected %h", PC, 32'h20); end
    n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL mp_pre_flush: got %b expected 0", flush); end
    n_chk++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL mp_pushpop_fv: got %b expected 1", fetch_valid); end
    tick();
    set_ex(1'b1, 32'h20, 1'b1, 1'b1, 32'h80);
    #1;
    n_chk++; if (update !== 1'b1) begin n_fail++; $display("FAIL mp_upd: got %b expected 1", update); end
    n_chk++; if (updatePC !== 32'h20) begin n_fail++; $display("FAIL mp_updpc: got %h expected %h", updatePC, 32'h20); end
    n_chk++; if (updateTarget !== 32'h80) begin n_fail++; $display("FAIL mp_updtgt: got %h expected %h", updateTarget, 32'h80); end
    n_chk++; if (mispredicted !== 1'b1) begin n_fail++; $display("FAIL mp_mis: got %b expected 1", mispredicted); end
    n_chk++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mp_flush: got %b expected 1", flush); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL mp_fv: got %b expected 0", fetch_valid); end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++; if (PC !== 32'h80) begin n_fail++; $display("FAIL mp_redirect: got %h expected %h", PC, 32'h80); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL mp_bubble_fv: got %b expected 0", fetch_valid); end
    tick();
    n_chk++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL mp_run_fv: got %b expected 1", fetch_valid); end
    n_chk++; if (PC !== 32'h80) begin n_fail++; $display("FAIL mp_run_pc: got %h expected %h", PC, 32'h80); end
    tick();
    fetch_ready = 1'b0;
    // Queue was cleared, so the head must be 0x80, not the suppressed 0x24.
    set_ex(1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL mp_cleared: got %b expected 0", order_err); end
  endtask

  // Non-branch predicted taken: mispredict without BTB update, to ex_pc+4.
  task automatic test_nonbranch_taken();
    do_reset();
    fetch_ready = 1'b1;
    set_btb(1'b1, 1'b1, 32'h200);
    tick();
    fetch_ready = 1'b0;
    set_btb(1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++; if (mispredicted !== 1'b1) begin n_fail++; $display("FAIL nb_mis: got %b expected 1", mispredicted); end
    n_chk++; if (update !== 1'b0) begin n_fail++; $display("FAIL nb_upd: got %b expected 0", update); end
    n_chk++; if (flush !== 1'b1) begin n_fail++; $display("FAIL nb_flush: got %b expected 1", flush); end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++; if (PC !== 32'h4) begin n_fail++; $display("FAIL nb_pc: got %h expected %h", PC, 32'h4); end
  endtask

  // Correct taken prediction {0x30,1,0x40}: update but no flush/redirect.
  task automatic test_correct_pred();
    do_reset();
    fetch_ready = 1'b1;
    set_btb(1'b1, 1'b1, 32'h30);
    tick();
    set_btb(1'b1, 1'b1, 32'h40);
    set_ex(1'b1, 32'h0, 1'b1, 1'b1, 32'h30);
    tick();
    fetch_ready = 1'b0;
    set_btb(1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 32'h30, 1'b1, 1'b1, 32'h40);
    #1;
    n_chk++; if (PC !== 32'h40) begin n_fail++; $display("FAIL ok_pc40: got %h expected %h", PC, 32'h40); end
    n_chk++; if (update !== 1'b1) begin n_fail++; $display("FAIL ok_upd: got %b expected 1", update); end
    n_chk++; if (updatePC !== 32'h30) begin n_fail++; $display("FAIL ok_updpc: got %h expected %h", updatePC, 32'h30); end
    n_chk++; if (mispredicted !== 1'b0) begin n_fail++; $display("FAIL ok_mis: got %b expected 0", mispredicted); end
    n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL ok_flush: got %b expected 0", flush); end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++; if (PC !== 32'h40) begin n_fail++; $display("FAIL ok_hold: got %h expected %h", PC, 32'h40); end
  endtask

  // Sticky order error from an empty-queue retire and from a PC mismatch,
  // then an asynchronous reset mid-fetch.
  task automatic test_order_err();
    do_reset();
    set_ex(1'b1, 32'h0, 1'b1, 1'b1, 32'h44);
    #1;
    n_chk++; if (update !== 1'b0) begin n_fail++; $display("FAIL oe_empty_upd: got %b expected 0", update); end
    n_chk++; if (mispredicted !== 1'b0) begin n_fail++; $display("FAIL oe_empty_mis: got %b expected 0", mispredicted); end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_chk++; if (order_err !== 1'b1) begin n_fail++; $display("FAIL oe_empty: got %b expected 1", order_err); end
    tick();
    tick();
    n_chk++; if (order_err !== 1'b1) begin n_fail++; $display("FAIL oe_sticky: got %b expected 1", order_err); end

    do_reset();
    fetch_ready = 1'b1;
    set_btb(1'b1, 1'b1, 32'h48);
    tick();
    set_btb(1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 32'h0, 1'b1, 1'b1, 32'h48);
    tick();
    fetch_ready = 1'b0;
    n_chk++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL oe_pre: got %b expected 0", order_err); end
    set_ex(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_chk++; if (order_err !== 1'b1) begin n_fail++; $display("FAIL oe_mismatch: got %b expected 1", order_err); end
    // Async reset between clock edges takes effect immediately.
    fetch_ready = 1'b1;
    tick();
    n_chk++; if (PC === 32'h0) begin n_fail++; $display("FAIL ar_pre_pc: got %h expected nonzero", PC); end
    #1 rst = 1'b0;
    #1;
    n_chk++; if (PC !== 32'h0) begin n_fail++; $display("FAIL ar_pc: got %h expected %h", PC, 32'h0); end
    n_chk++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL ar_order: got %b expected 0", order_err); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL ar_fv: got %b expected 0", fetch_valid); end
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential_fill();
    test_mispredict();
    test_nonbranch_taken();
    test_correct_pred();
    test_order_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_fetch_pc.md
Name: btb_fetch_pc

Overview:
- Fetch-side PC generator and prediction tracker directly upstream and downstream of the branch target buffer.
- Drives the PC that the BTB looks up and consumes its valid/target/predictedTaken outputs to choose the next PC.
- Records each fetched prediction in an in-order in-flight queue and checks it against the EX-stage branch outcome.
- Produces the BTB update/mispredicted controls and the pipeline flush/redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, in-flight prediction queue entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- fetch_ready  in  1  IF/ID can accept an instruction this cycle.
- btb_valid  in  1  BTB hit for current PC.
- btb_target  in  32  BTB predicted target.
- btb_taken  in  1  BTB taken prediction.
- ex_valid  in  1  an instruction retires from EX this cycle (in program order).
- ex_pc  in  32  PC of that instruction.
- ex_is_branch  in  1  that instruction is a control transfer.
- ex_taken  in  1  resolved direction.
- ex_target  in  32  resolved target.
- PC  out  32  current fetch PC, also the BTB lookup address.
- fetch_valid  out  1  PC is issued to IF this cycle.
- pred_taken_o  out  1  prediction sent with the fetched instruction.
- update  out  1  BTB write enable.
- updatePC  out  32  BTB update address.
- updateTarget  out  32  BTB update target.
- mispredicted  out  1  prediction was wrong.
- flush  out  1  kill younger instructions in IF/ID/EX.
- order_err  out  1  sticky: ex_pc ≠ head entry pc, or ex_valid with empty queue.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, queue empty, state=RUN, order_err=0. All other outputs are 0 while reset is held.
- pred = btb_valid & btb_taken. pred_taken_o = pred.
- fetch_valid = (state==RUN) & fetch_ready & !full & !flush.
- Fire (fetch_valid=1): push {PC, pred, btb_target} into the queue. Next cycle, PC = pred ? btb_target : PC+4 (mod 2^32 wrap).
- No fire: PC holds.
- Resolution, combinational in the ex_valid cycle when the queue is not empty:
  - Pop the head entry.
  - If ex_is_branch: update=1, updatePC=ex_pc, updateTarget=ex_target.
  - mispredicted = ex_is_branch & ((head.pred≠ex_taken) | (ex_taken & head.tgt≠ex_target)).
  - A non-branch predicted taken also mispredicts: mispredicted=1, update=0. It is redirected to ex_pc+4.
- Mispredict:
  - flush=1 the same cycle.
  - Queue cleared at the clock edge; the push from that cycle is suppressed.
  - PC := ex_taken&ex_is_branch ? ex_target : ex_pc+4.
  - state := BUBBLE.
- FSM:
  - RUN → BUBBLE on mispredict.
  - BUBBLE → RUN after 1 cycle. fetch_valid=0 in BUBBLE so the BTB reads the new PC.
  - A mispredict is not possible in BUBBLE because the queue is empty.
- Simultaneous push and pop without mispredict: both occur, count unchanged. When the queue is full, a pop that cycle does NOT enable a push (full is the registered count).
- ex_valid with empty queue: no pop, update=0, mispredicted=0, order_err:=1.
- ex_pc≠head.pc: order_err:=1. The pop and compare still proceed.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- update, mispredicted and flush are combinational from the EX inputs plus queue head, with 0-cycle latency. BTB writes occur at the following clock edge.

Test Plan:
1. Reset release, fetch_ready=1, btb_valid=0 → PC sequence 0x0,0x4,0x8; fetch_valid=1 each cycle.
2. At PC=0x10 drive btb_valid=1,btb_taken=1,btb_target=0x100 → next PC=0x100, queue entry pred=1.
3. Fill 4 entries with ex_valid=0 → fetch_valid=0 and PC holds. One ex_valid pop → fetch resumes next cycle.
4. Head {0x20,pred=0}; ex_is_branch=1,ex_taken=1,ex_target=0x80 → update=1, updatePC=0x20, updateTarget=0x80, mispredicted=1, flush=1. Next PC=0x80, one bubble cycle, queue empty.
5. Head {0x30,pred=1,tgt=0x40}; EX taken to 0x40 → update=1, mispredicted=0, flush=0, no redirect.
6. ex_valid on empty queue, and separately ex_pc=0x44 vs head 0x48 → order_err=1 and stays 1 until reset. Async reset mid-fetch → PC=RESET_PC immediately.
